// File: rtl/speriph_rr_combiner.sv
// Round-robin merge of NB_PLUGS peripheral-bus plugs onto one slave port.
// Responses come back in order and are routed by a tag FIFO of granted plug indices.
module speriph_rr_combiner #(
  parameter int NB_PLUGS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 5,
  parameter int MAX_OUTST  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      plug_req_i     [NB_PLUGS],
  input  logic [ADDR_WIDTH-1:0]     plug_add_i     [NB_PLUGS],
  input  logic                      plug_wen_i     [NB_PLUGS],
  input  logic [DATA_WIDTH-1:0]     plug_wdata_i   [NB_PLUGS],
  input  logic [DATA_WIDTH/8-1:0]   plug_be_i      [NB_PLUGS],
  input  logic [ID_WIDTH-1:0]       plug_id_i      [NB_PLUGS],
  output logic                      plug_gnt_o     [NB_PLUGS],
  output logic                      plug_r_valid_o [NB_PLUGS],
  output logic                      plug_r_opc_o,
  output logic [ID_WIDTH-1:0]       plug_r_id_o,
  output logic [DATA_WIDTH-1:0]     plug_r_rdata_o,
  output logic                      slv_req_o,
  output logic [ADDR_WIDTH-1:0]     slv_add_o,
  output logic                      slv_wen_o,
  output logic [DATA_WIDTH-1:0]     slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   slv_be_o,
  output logic [ID_WIDTH-1:0]       slv_id_o,
  input  logic                      slv_gnt_i,
  input  logic                      slv_r_valid_i,
  input  logic                      slv_r_opc_i,
  input  logic [ID_WIDTH-1:0]       slv_r_id_i,
  input  logic [DATA_WIDTH-1:0]     slv_r_rdata_i,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                      err_o
);

  localparam int PTR_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
  localparam int TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic             full;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] tag_mem [MAX_OUTST];
  logic [TAG_W-1:0] wr_ptr;
  logic [TAG_W-1:0] rd_ptr;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             err;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] p);
    if (MAX_OUTST == 1) return '0;
    return (p == TAG_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping; defaults to plug 0 when idle.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NB_PLUGS; k++) begin
      idx     = (int'(rr_ptr) + k) % NB_PLUGS;
      any_req = any_req | plug_req_i[k];
      if (!found && plug_req_i[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign full      = (count == CNT_W'(MAX_OUTST));
  assign slv_req_o = rst_ni & any_req & ~full;
  assign push      = slv_req_o & slv_gnt_i;
  assign pop       = rst_ni & slv_r_valid_i & (count != '0);
  assign head      = tag_mem[rd_ptr];

  assign slv_add_o   = plug_add_i[winner];
  assign slv_wen_o   = plug_wen_i[winner];
  assign slv_wdata_o = plug_wdata_i[winner];
  assign slv_be_o    = plug_be_i[winner];
  assign slv_id_o    = plug_id_i[winner];

  assign plug_r_opc_o   = slv_r_opc_i;
  assign plug_r_id_o    = slv_r_id_i;
  assign plug_r_rdata_o = slv_r_rdata_i;

  always_comb begin
    for (int i = 0; i < NB_PLUGS; i++) begin
      plug_gnt_o[i]     = push && (winner == PTR_W'(i));
      plug_r_valid_o[i] = pop && (head == PTR_W'(i));
    end
  end

  // A response arriving with nothing outstanding is flagged, never routed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == PTR_W'(NB_PLUGS - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= next_tag(wr_ptr);
      end
      if (pop) rd_ptr <= next_tag(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (slv_r_valid_i && (count == '0)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  assign outst_cnt_o = count;
  assign err_o       = err;

endmodule

// File: tb/tb_speriph_rr_combiner.sv
// Directed and randomized checks of the round-robin combiner against a queue-based model.
module tb_speriph_rr_combiner;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int MO = 2;
  localparam int CW = $clog2(MO) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic            plug_req [NB];
  logic [AW-1:0]   plug_add [NB];
  logic            plug_wen [NB];
  logic [DW-1:0]   plug_wdata [NB];
  logic [DW/8-1:0] plug_be [NB];
  logic [IW-1:0]   plug_id [NB];
  logic            plug_gnt [NB];
  logic            plug_r_valid [NB];
  logic            r_opc;
  logic [IW-1:0]   r_id;
  logic [DW-1:0]   r_rdata;
  logic            slv_req, slv_wen, slv_gnt, slv_r_valid, slv_r_opc;
  logic [AW-1:0]   slv_add;
  logic [DW-1:0]   slv_wdata, slv_r_rdata;
  logic [DW/8-1:0] slv_be;
  logic [IW-1:0]   slv_id, slv_r_id;
  logic [CW-1:0]   outst_cnt;
  logic            err;
  logic [NB-1:0]   gnt_v, rv_v;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int      rr;
  int      q[$];
  bit      err_m;
  int      exp_w;
  bit      exp_req;
  logic [NB-1:0] exp_gnt, exp_rv;
  int      exp_cnt;

  speriph_rr_combiner #(.NB_PLUGS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ID_WIDTH(IW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .plug_req_i(plug_req), .plug_add_i(plug_add), .plug_wen_i(plug_wen),
    .plug_wdata_i(plug_wdata), .plug_be_i(plug_be), .plug_id_i(plug_id),
    .plug_gnt_o(plug_gnt), .plug_r_valid_o(plug_r_valid),
    .plug_r_opc_o(r_opc), .plug_r_id_o(r_id), .plug_r_rdata_o(r_rdata),
    .slv_req_o(slv_req), .slv_add_o(slv_add), .slv_wen_o(slv_wen),
    .slv_wdata_o(slv_wdata), .slv_be_o(slv_be), .slv_id_o(slv_id),
    .slv_gnt_i(slv_gnt), .slv_r_valid_i(slv_r_valid), .slv_r_opc_i(slv_r_opc),
    .slv_r_id_i(slv_r_id), .slv_r_rdata_i(slv_r_rdata),
    .outst_cnt_o(outst_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      gnt_v[i] = plug_gnt[i];
      rv_v[i]  = plug_r_valid[i];
    end
  end

  task automatic set_inputs(input logic [NB-1:0] req, input bit g, input bit rv);
    for (int i = 0; i < NB; i++) begin
      plug_req[i]   = req[i];
      plug_add[i]   = $urandom;
      plug_wen[i]   = 1'($urandom);
      plug_wdata[i] = $urandom;
      plug_be[i]    = 4'($urandom);
      plug_id[i]    = 5'($urandom);
    end
    slv_gnt     = g;
    slv_r_valid = rv;
    slv_r_opc   = 1'($urandom);
    slv_r_id    = 5'($urandom);
    slv_r_rdata = $urandom;
  endtask

  // Drive one cycle's inputs and compute what the rules say the outputs must be.
  task automatic apply(input logic [NB-1:0] req, input bit g, input bit rv);
    @(negedge clk);
    set_inputs(req, g, rv);
    exp_req = (req != 0) && (q.size() < MO);
    exp_w = 0;
    for (int k = 0; k < NB; k++) begin
      int j;
      j = (rr + k) % NB;
      if (req[j]) begin exp_w = j; break; end
    end
    exp_gnt = (exp_req && g) ? (NB'(1) << exp_w) : '0;
    exp_rv  = (rv && q.size() > 0) ? (NB'(1) << q[0]) : '0;
    exp_cnt = q.size();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (slv_r_valid && q.size() == 0) err_m = 1'b1;
    if (exp_rv != 0) void'(q.pop_front());
    if (exp_gnt != 0) begin
      q.push_back(exp_w);
      rr = (exp_w + 1) % NB;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_inputs('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    rr = 0; q.delete(); err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_inputs('1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (slv_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", slv_req); end
    checks++; if (gnt_v !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt_v); end
    checks++; if (rv_v !== '0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rv_v); end
    checks++; if (outst_cnt !== '0 || err !== 1'b0) begin errors++; $display("FAIL reset_state cnt %0d err %0b exp 0 0", outst_cnt, err); end
    do_reset();
    apply(4'b0001, 1'b1, 1'b0);
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", gnt_v); end
    advance();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      apply(4'b0011, 1'b1, c > 0);
      checks++; if (gnt_v !== ((c % 2 == 0) ? 4'b0001 : 4'b0010)) begin errors++; $display("FAIL alt_gnt c=%0d got %b", c, gnt_v); end
      if (c > 0) begin
        checks++; if (rv_v !== (((c - 1) % 2 == 0) ? 4'b0001 : 4'b0010)) begin errors++; $display("FAIL alt_rvalid c=%0d got %b", c, rv_v); end
      end
      advance();
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    apply(4'b0100, 1'b1, 1'b0);
    checks++; if (gnt_v !== 4'b0100) begin errors++; $display("FAIL rr_first got %b exp 0100", gnt_v); end
    advance();
    apply(4'b1010, 1'b1, 1'b1);
    checks++; if (gnt_v !== 4'b1000) begin errors++; $display("FAIL rr_second got %b exp 1000", gnt_v); end
    checks++; if (rv_v !== 4'b0100) begin errors++; $display("FAIL rr_rvalid got %b exp 0100", rv_v); end
    advance();
    apply(4'b1010, 1'b1, 1'b0);
    checks++; if (gnt_v !== 4'b0010) begin errors++; $display("FAIL rr_third got %b exp 0010", gnt_v); end
    advance();
  endtask

  task automatic test_full();
    do_reset();
    apply(4'b1111, 1'b1, 1'b0); advance();
    apply(4'b1111, 1'b1, 1'b0); advance();
    apply(4'b1111, 1'b1, 1'b0);
    checks++; if (slv_req !== 1'b0 || gnt_v !== '0) begin errors++; $display("FAIL full_block req %0b gnt %b exp 0 0", slv_req, gnt_v); end
    checks++; if (outst_cnt !== CW'(2)) begin errors++; $display("FAIL full_cnt got %0d exp 2", outst_cnt); end
    advance();
    apply(4'b1111, 1'b1, 1'b1);
    checks++; if (slv_req !== 1'b0 || rv_v !== 4'b0001) begin errors++; $display("FAIL full_pop req %0b rv %b exp 0 0001", slv_req, rv_v); end
    advance();
    apply(4'b1111, 1'b1, 1'b0);
    checks++; if (outst_cnt !== CW'(1) || gnt_v !== 4'b0100) begin errors++; $display("FAIL full_resume cnt %0d gnt %b exp 1 0100", outst_cnt, gnt_v); end
    advance();
  endtask

  task automatic test_unexpected();
    do_reset();
    apply('0, 1'b0, 1'b1);
    checks++; if (rv_v !== '0 || err !== 1'b0) begin errors++; $display("FAIL unexp_same rv %b err %0b exp 0 0", rv_v, err); end
    advance();
    apply('0, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || outst_cnt !== '0) begin errors++; $display("FAIL unexp_err err %0b cnt %0d exp 1 0", err, outst_cnt); end
    advance();
    repeat (3) begin apply('0, 1'b0, 1'b0); advance(); end
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %0b exp 1", err); end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(4'b0001, 1'b1, 1'b0); advance();
    for (int c = 1; c < 7; c++) begin
      apply(NB'(1) << (c % NB), 1'b1, 1'b1);
      checks++; if (rv_v !== (NB'(1) << ((c - 1) % NB)) || gnt_v !== (NB'(1) << (c % NB))) begin
        errors++; $display("FAIL wrap c=%0d rv %b gnt %b", c, rv_v, gnt_v); end
      checks++; if (outst_cnt !== CW'(1)) begin errors++; $display("FAIL wrap_cnt c=%0d got %0d exp 1", c, outst_cnt); end
      advance();
    end
  endtask

  // Runs straight after test_unexpected so err is set and must be cleared.
  task automatic test_reset_mid();
    apply(4'b0011, 1'b1, 1'b0); advance();
    apply(4'b0011, 1'b1, 1'b0); advance();
    @(negedge clk);
    set_inputs('1, 1'b1, 1'b1);
    #1;
    checks++; if (outst_cnt !== CW'(2)) begin errors++; $display("FAIL mid_precnt got %0d exp 2", outst_cnt); end
    rst_n = 1'b0;
    rr = 0; q.delete(); err_m = 1'b0;
    #1;
    checks++; if (slv_req !== 1'b0 || gnt_v !== '0 || rv_v !== '0) begin errors++; $display("FAIL mid_outputs req %0b gnt %b rv %b exp 0", slv_req, gnt_v, rv_v); end
    @(negedge clk);
    set_inputs('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    checks++; if (outst_cnt !== '0 || err !== 1'b0) begin errors++; $display("FAIL mid_cleared cnt %0d err %0b exp 0 0", outst_cnt, err); end
    apply(4'b1010, 1'b1, 1'b0);
    checks++; if (gnt_v !== 4'b0010) begin errors++; $display("FAIL mid_rrptr got %b exp 0010", gnt_v); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NB-1:0] req;
      bit g, rv;
      req = NB'($urandom_range(0, 15));
      g   = 1'($urandom);
      rv  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      apply(req, g, rv);
      checks++; if (slv_req !== exp_req || gnt_v !== exp_gnt || rv_v !== exp_rv) begin
        errors++; $display("FAIL rand_ctrl c=%0d req %0b gnt %b rv %b exp %0b %b %b", c, slv_req, gnt_v, rv_v, exp_req, exp_gnt, exp_rv); end
      checks++; if ({slv_add, slv_wen, slv_wdata, slv_be, slv_id} !==
                    {plug_add[exp_w], plug_wen[exp_w], plug_wdata[exp_w], plug_be[exp_w], plug_id[exp_w]}) begin
        errors++; $display("FAIL rand_mux c=%0d add %h exp %h", c, slv_add, plug_add[exp_w]); end
      checks++; if ({r_opc, r_id, r_rdata} !== {slv_r_opc, slv_r_id, slv_r_rdata}) begin
        errors++; $display("FAIL rand_resp c=%0d rdata %h exp %h", c, r_rdata, slv_r_rdata); end
      checks++; if (outst_cnt !== CW'(exp_cnt) || err !== err_m) begin
        errors++; $display("FAIL rand_state c=%0d cnt %0d err %0b exp %0d %0b", c, outst_cnt, err, exp_cnt, err_m); end
      advance();
    end
  endtask

  initial begin
    rr = 0; err_m = 1'b0;
    set_inputs('0, 1'b0, 1'b0);
    test_reset();
    test_alternate();
    test_rr_order();
    test_full();
    test_wrap();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/speriph_rr_combiner.md
SPERIPH_RR_COMBINER -- requirements
Module: speriph_rr_combiner

Interface
REQ-001 SHALL have parameter NB_PLUGS, default 2: number of peripheral-bus plugs merged onto one slave, range 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 5: request/response id width.
REQ-005 SHALL have parameter MAX_OUTST, default 2: max outstanding granted transactions, range 1..8, power of two.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset; one clock, asynchronous, active-low.
REQ-008 SHALL have ports plug_req_i [NB_PLUGS], plug_add_i [NB_PLUGS][ADDR_WIDTH], plug_wen_i [NB_PLUGS], plug_wdata_i [NB_PLUGS][DATA_WIDTH], plug_be_i [NB_PLUGS][DATA_WIDTH/8] and plug_id_i [NB_PLUGS][ID_WIDTH], all inputs: upstream request channel per plug.
REQ-009 SHALL have ports plug_gnt_o [NB_PLUGS], output: per-plug grant.
REQ-010 SHALL have ports plug_r_valid_o [NB_PLUGS], output: per-plug response valid.
REQ-011 SHALL have ports plug_r_opc_o (1), plug_r_id_o (ID_WIDTH) and plug_r_rdata_o (DATA_WIDTH), all outputs: response payload, shared by all plugs.
REQ-012 SHALL have ports slv_req_o, slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o and slv_id_o, all outputs: merged request to the downstream slave.
REQ-013 SHALL have ports slv_gnt_i, slv_r_valid_i, slv_r_opc_i, slv_r_id_i and slv_r_rdata_i, all inputs: downstream grant and response.
REQ-014 SHALL have port outst_cnt_o, output, $clog2(MAX_OUTST)+1 bits: number of outstanding transactions.
REQ-015 SHALL have port err_o, output, 1 bit: sticky flag for an unexpected response.

Function
REQ-016 SHALL compute the winner combinationally each cycle as the first plug with req=1 at or after rr_ptr, searching upward with wrap from NB_PLUGS-1 to 0.
REQ-017 SHALL drive slv_req_o = (|plug_req_i) & ~full; slv_add/wen/wdata/be/id SHALL carry the winner's fields, and SHALL be plug 0 fields when there is no request.
REQ-018 SHALL drive plug_gnt_o[winner] = slv_gnt_i & slv_req_o; all other grants SHALL be 0; at most one grant per cycle.
REQ-019 SHALL, on handshake (slv_req_o & slv_gnt_i), push the winner index into an in-order tag FIFO of depth MAX_OUTST and set rr_ptr to (winner+1) mod NB_PLUGS.
REQ-020 SHALL leave rr_ptr unchanged when there is no handshake (request pending but not granted, or idle).
REQ-021 SHALL block slv_req_o while full (count == MAX_OUTST), even if a pop occurs in the same cycle; plug grants SHALL be 0 while full.
REQ-022 SHALL, on slv_r_valid_i with FIFO non-empty, assert plug_r_valid_o[head] in the same cycle, pop the FIFO, and keep all other plug_r_valid_o at 0.
REQ-023 SHALL pass plug_r_opc/id/rdata combinationally from slv_r_*; latency is 0 cycles in both directions.
REQ-024 SHALL, on slv_r_valid_i with FIFO empty, assert no plug_r_valid_o, leave the count unchanged, and set err_o=1 on the next edge, sticky until reset.
REQ-025 SHALL, on simultaneous push and pop, leave the count unchanged and keep the FIFO order correct; pointers SHALL wrap modulo MAX_OUTST.
REQ-026 SHALL set outst_cnt_o = count register (pushes - pops); it SHALL never exceed MAX_OUTST.
REQ-027 The slave SHALL respond in order, at least one cycle after its grant; same-cycle responses SHALL be treated per REQ-024.

Reset
REQ-028 SHALL, on rst_ni low, asynchronously clear rr_ptr=0, FIFO pointers=0, count=0 and err_o=0.
REQ-029 SHALL hold all grants, plug_r_valid_o and slv_req_o at 0 while rst_ni is low; outstanding transactions at reset SHALL be discarded.
REQ-030 SHALL allow the first request after deassertion to be granted in that cycle.

Verification
REQ-031 NB_PLUGS=2, both plugs requesting continuously, slv_gnt=1, response 1 cycle later -> grants alternate 0,1,0,1; r_valid is routed to the matching plug each time.
REQ-032 NB_PLUGS=4, only plug 2 requesting, then plugs 1 and 3 requesting -> plug 2 granted; next grant goes to plug 3 (rr_ptr=3), then plug 1.
REQ-033 MAX_OUTST=2, responses withheld -> 2 grants, then slv_req_o=0 and outst_cnt_o=2; one response -> count 1, next grant on the following cycle.
REQ-034 slv_r_valid_i pulse with count=0 -> no plug_r_valid_o, err_o=1 from the next cycle, stays 1.
REQ-035 Same-cycle push and pop at count=1 -> count stays 1 and FIFO order is preserved across the pointer wrap.
REQ-036 rst_ni asserted mid-transaction with count=2 -> outputs 0 immediately; after release count=0, err_o=0, rr_ptr=0.
